fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the instruction memory read address.
- Captures the returned instruction into the IF/ID pipeline register.
- Honours load-use stalls from the hazard detection unit and taken-branch/jump redirects from EX, and counts stall cycles for lab reporting.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000000, bubble word (sll $0,$0,0) written into IF/ID on redirect or reset.
- CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  load-use stall from hazard unit; hold PC and IF/ID.
- branch_taken  input  1  redirect request from EX (branch resolved taken, or jump).
- branch_target  input  32  redirect PC; bits [1:0] ignored (forced 00).
- instr_in  input  32  instruction from instruction memory for the current pc_out (combinational read).
- pc_out  output  32  current PC, wired to the instruction memory read address.
- ifid_instr  output  32  IF/ID instruction register.
- ifid_pc_plus4  output  32  IF/ID PC+4 register.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- stall_cycles  output  CNT_WIDTH  saturating count of cycles in which stall was honoured.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the rising edge.
- Reset values: pc_out=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0, stall_cycles=0.
- Reset mid-operation: discards any stall or redirect asserted in the same cycle.
- Priority per edge: reset > branch_taken > stall > normal advance.
- Normal advance (no reset/branch/stall):
  - pc_out <= pc_out+4.
  - ifid_instr <= instr_in.
  - ifid_pc_plus4 <= pc_out+4.
  - ifid_valid <= 1.
- Stall (stall=1, branch_taken=0):
  - pc_out, ifid_instr, ifid_pc_plus4 and ifid_valid all hold.
  - stall_cycles increments, saturating at all-ones.
  - A stall held for N consecutive cycles adds exactly N.
- Redirect (branch_taken=1):
  - pc_out <= {branch_target[31:2],2'b00}.
  - IF/ID flushed: ifid_instr <= NOP_INSTR, ifid_valid <= 0, ifid_pc_plus4 <= 0.
- Simultaneous branch_taken and stall: redirect wins (the EX instruction is older than the stalled ID one); stall_cycles does not increment.
- Latency:
  - instr_in reflects pc_out in the same cycle.
  - The instruction appears in IF/ID one edge later.
  - The first valid IF/ID instruction after reset deassertion appears at the first non-stalled edge.
- PC arithmetic: 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0 with no flag.
- pc_out[1:0] is always 00.
- No combinational path from stall or branch_taken to pc_out; pc_out is purely registered.
- Stall while ifid_valid=0 is legal: the bubble is held and the counter still increments.

Decomposition:
- Shared defines header (alongside the other pipeline `define headers):
  - NOP_INSTR and RESET_PC constants.
  - PC increment constant (4).
- One natural sub-module: pc_register, a 32-bit register with synchronous reset, hold-enable and load-value. It is instantiated once for the PC.
- The IF/ID register and the counter stay inline.

Test Plan:
- Reset: assert reset 2 cycles with instr_in=32'h8D090000 -> pc_out=0, ifid_valid=0, ifid_instr=0, stall_cycles=0; first edge after release gives ifid_instr=32'h8D090000, ifid_pc_plus4=4, pc_out=4.
- Load-use stall: program lw $t1,0($t0) at 0, addi $t1,$t1,1 (32'h21290001) at 4; assert stall for 1 cycle once addi is fetched -> pc_out stays 8 and ifid_instr stays 32'h21290001 for that edge; stall_cycles=1; advance resumes next edge.
- Redirect: at pc_out=12 assert branch_taken with branch_target=32'h00000042 -> next edge pc_out=32'h40, ifid_instr=NOP_INSTR, ifid_valid=0; following edge fetches from 32'h40.
- Simultaneous stall and branch_taken with target 32'h20 -> pc_out=32'h20, IF/ID flushed, stall_cycles unchanged.
- Counter saturation: with CNT_WIDTH=4, hold stall 20 cycles -> stall_cycles reaches 4'hF and stays.
- PC wrap plus reset mid-stall: redirect to 32'hFFFFFFFC, advance -> pc_out=0; then assert stall and reset together -> reset values, stall ignored.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Purpose: shared constants, types and helpers for the MIPS instruction-fetch stage.
// Latency: none; this file only declares types, constants and pure functions.
// Backpressure: none; stall/redirect priority is resolved by decode_act below.
package fetch_stage_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  // sll $0,$0,0 : the architectural no-op used as a pipeline bubble
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  // What the fetch stage does on the coming edge, highest priority first
  typedef enum logic [1:0] {
    ACT_RESET    = 2'd0,
    ACT_REDIRECT = 2'd1,
    ACT_STALL    = 2'd2,
    ACT_ADVANCE  = 2'd3
  } fetch_act_e;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  // Force a byte address onto a word boundary (low two bits cleared)
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & WORD_MASK;
  endfunction

  // Reset beats redirect beats stall beats normal advance. A redirect wins
  // over a stall because the instruction in EX is older than the stalled
  // one sitting in ID, so its control-flow change must take effect.
  function automatic fetch_act_e decode_act(input logic reset,
                                            input logic branch_taken,
                                            input logic stall);
    if (reset)             return ACT_RESET;
    else if (branch_taken) return ACT_REDIRECT;
    else if (stall)        return ACT_STALL;
    else                   return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Purpose: 32-bit program counter with sync reset, redirect load and hold enable.
// Latency: one edge from load/advance request to the new PC appearing on pc.
// Backpressure: hold=1 freezes the PC; load overrides hold; reset overrides all.
module fetch_stage_pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] pc
);

  // Reset value is aligned too so pc[1:0] can never leave 00
  localparam logic [31:0] RESET_ALIGNED = RESET_VALUE & WORD_MASK;

  // PC update: reset > load (redirect) > hold (stall) > sequential advance
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_ALIGNED;
    end else if (load) begin
      pc <= word_align(load_value);
    end else if (!hold) begin
      pc <= pc + PC_INCR;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: MIPS IF stage - owns the PC, drives imem address, fills the IF/ID register.
// Latency: instr_in is read combinationally for pc_out; it lands in IF/ID one edge later.
// Backpressure: stall holds PC and IF/ID and counts the cycle; branch_taken flushes IF/ID and wins over stall.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PC_RESET_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_WORD,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic [31:0]          instr_in,
  output logic [31:0]          pc_out,
  output logic [31:0]          ifid_instr,
  output logic [31:0]          ifid_pc_plus4,
  output logic                 ifid_valid,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  fetch_act_e           act;
  logic [31:0]          pc_plus4;
  ifid_t                ifid_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  // Resolve this cycle's control inputs into a single prioritised action
  always_comb begin
    act = decode_act(reset, branch_taken, stall);
  end

  // Sequential fetch address; wraps modulo 2^32 with no flag
  assign pc_plus4 = pc_out + PC_INCR;

  // The PC itself lives in its own register; its output is purely registered
  fetch_stage_pc_register #(
    .RESET_VALUE (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .hold       (stall),
    .load       (branch_taken),
    .load_value (branch_target),
    .pc         (pc_out)
  );

  // IF/ID register: capture on advance, hold on stall, bubble on redirect/reset
  always_ff @(posedge clk) begin
    unique case (act)
      ACT_RESET, ACT_REDIRECT: begin
        ifid_q.instr    <= NOP_INSTR;
        ifid_q.pc_plus4 <= '0;
        ifid_q.valid    <= 1'b0;
      end
      ACT_ADVANCE: begin
        ifid_q.instr    <= instr_in;
        ifid_q.pc_plus4 <= pc_plus4;
        ifid_q.valid    <= 1'b1;
      end
      default: begin
        ifid_q <= ifid_q;
      end
    endcase
  end

  // Saturating count of edges on which a stall was actually honoured
  always_ff @(posedge clk) begin
    if (act == ACT_RESET) begin
      stall_cnt_q <= '0;
    end else if (act == ACT_STALL && stall_cnt_q != CNT_MAX) begin
      stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid    = ifid_q.valid;
  assign stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: directed-vector scoreboard bench for fetch_stage (CNT_WIDTH=4).
// Latency: each vector's expectation is checked 1 time unit after the edge it drives.
// Backpressure: driver pushes expectations; an independent monitor pops and compares.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [3:0]  stall_cycles;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_n = 0;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000),
    .CNT_WIDTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_in      (instr_in),
    .pc_out        (pc_out),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .stall_cycles  (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small instruction memory with a combinational read
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8D09_0000; // lw   $t1,0($t0)
      32'h0000_0004: return 32'h2129_0001; // addi $t1,$t1,1
      32'h0000_0008: return 32'h0109_5020; // add  $t2,$t0,$t1
      32'h0000_000C: return 32'hAC0A_0004; // sw   $t2,4($zero)
      32'h0000_0020: return 32'h2222_2222;
      32'h0000_0040: return 32'h2108_FFFF;
      32'hFFFF_FFFC: return 32'h1234_5678;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  always_comb instr_in = imem(pc_out);

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, got, want);
    end
  endtask

  // Monitor: every edge that has a pending expectation is compared
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_out",        e.idx, pc_out,               e.pc);
        chk("ifid_instr",    e.idx, ifid_instr,           e.instr);
        chk("ifid_pc_plus4", e.idx, ifid_pc_plus4,        e.pc4);
        chk("ifid_valid",    e.idx, {31'd0, ifid_valid},  {31'd0, e.valid});
        chk("stall_cycles",  e.idx, {28'd0, stall_cycles}, {28'd0, e.cnt});
      end
    end
  end

  // Driver: apply inputs for the next edge and queue what that edge must produce
  task automatic step(input logic r, input logic s, input logic b,
                      input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_v,
                      input logic [3:0] e_cnt);
    exp_t e;
    @(negedge clk);
    reset         = r;
    stall         = s;
    branch_taken  = b;
    branch_target = tgt;
    e.idx   = vec_n;
    e.pc    = e_pc;
    e.instr = e_instr;
    e.pc4   = e_pc4;
    e.valid = e_v;
    e.cnt   = e_cnt;
    exp_q.push_back(e);
    vec_n++;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    //    rst stl br  target        pc            instr         pc+4          v  cnt
    // Reset held two edges
    step(1, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        0, 4'd0);
    step(1, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        0, 4'd0);
    // First valid fetch right after release, then addi
    step(0, 0, 0, 32'h0,         32'h4,        32'h8D090000, 32'h4,        1, 4'd0);
    step(0, 0, 0, 32'h0,         32'h8,        32'h21290001, 32'h8,        1, 4'd0);
    // Load-use stall: everything holds, counter steps
    step(0, 1, 0, 32'h0,         32'h8,        32'h21290001, 32'h8,        1, 4'd1);
    step(0, 0, 0, 32'h0,         32'hC,        32'h01095020, 32'hC,        1, 4'd1);
    // Redirect with misaligned target, then fetch from the target
    step(0, 0, 1, 32'h42,        32'h40,       32'h0,        32'h0,        0, 4'd1);
    step(0, 0, 0, 32'h0,         32'h44,       32'h2108FFFF, 32'h44,       1, 4'd1);
    // Redirect and stall together: redirect wins, counter unchanged
    step(0, 1, 1, 32'h20,        32'h20,       32'h0,        32'h0,        0, 4'd1);
    // Stall over a bubble still counts
    step(0, 1, 0, 32'h0,         32'h20,       32'h0,        32'h0,        0, 4'd2);
    step(0, 0, 0, 32'h0,         32'h24,       32'h22222222, 32'h24,       1, 4'd2);
    step(0, 0, 1, 32'h23,        32'h20,       32'h0,        32'h0,        0, 4'd2);
    // Long stall saturates the 4-bit counter at F
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0, 32'h0, 32'h20, 32'h0, 32'h0, 0,
           (2 + i > 15) ? 4'hF : 4'(2 + i));
    end
    // PC wrap: FFFFFFFC + 4 = 0
    step(0, 0, 1, 32'hFFFFFFFF,  32'hFFFFFFFC, 32'h0,        32'h0,        0, 4'hF);
    step(0, 0, 0, 32'h0,         32'h0,        32'h12345678, 32'h0,        1, 4'hF);
    step(0, 0, 0, 32'h0,         32'h4,        32'h8D090000, 32'h4,        1, 4'hF);
    // Reset during stall: stall ignored, everything back to reset values
    step(1, 1, 0, 32'h0,         32'h0,        32'h0,        32'h0,        0, 4'd0);
    step(0, 1, 0, 32'h0,         32'h0,        32'h0,        32'h0,        0, 4'd1);
    // Reset during redirect: redirect ignored
    step(1, 0, 1, 32'h80,        32'h0,        32'h0,        32'h0,        0, 4'd0);
    step(0, 0, 0, 32'h0,         32'h4,        32'h8D090000, 32'h4,        1, 4'd0);

    // Let the monitor drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog time=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
